// File: rtl/tracker_pkg.sv
// Shared types and defaults for the pattern grid editor.
// Repeat timing constants are used only when EDIT_REPEAT_EN is defined.
package tracker_pkg;

   typedef enum logic [1:0] {
      EDIT_NONE = 2'b00,
      EDIT_INC  = 2'b01,
      EDIT_DEC  = 2'b10,
      EDIT_DEL  = 2'b11
   } edit_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_MODIFY,
      ST_WRITE
   } ed_state_t;

   localparam int GRID_W_DEF = 80;
   localparam int GRID_H_DEF = 30;

   localparam logic [7:0] CELL_EMPTY = 8'h00;

   localparam logic [23:0] REPEAT_DELAY  = 24'd10_000_000;
   localparam logic [23:0] REPEAT_PERIOD = 24'd2_500_000;

   // Saturating cell update; out-of-range values snap to maxv.
   function automatic logic [7:0] next_value(
      input edit_t      cmd,
      input logic [7:0] v,
      input logic [7:0] maxv
   );
      logic [7:0] nv;
      nv = v;
      unique case (cmd)
         EDIT_INC: nv = (v >= maxv) ? maxv : v + 8'd1;
         EDIT_DEC: nv = (v > maxv)  ? maxv :
                        (v <= 8'd1) ? v    : v - 8'd1;
         EDIT_DEL: nv = CELL_EMPTY;
         default:  nv = v;
      endcase
      return nv;
   endfunction

endpackage

// File: rtl/edit_repeat_timer.sv
// Auto-repeat strobe for held increment/decrement commands.
// Compiled only when EDIT_REPEAT_EN is defined.
`ifdef EDIT_REPEAT_EN
module edit_repeat_timer
   import tracker_pkg::*;
#(
   parameter logic [23:0] DELAY  = REPEAT_DELAY,
   parameter logic [23:0] PERIOD = REPEAT_PERIOD
) (
   input  logic  clk,
   input  logic  Reset,
   input  edit_t i_cmd,
   input  logic  i_accept,
   output logic  o_repeat
);

   logic        r_active;
   logic        r_first;
   logic [23:0] r_cnt;
   edit_t       r_cmd;
   logic        w_rep_cmd;
   logic [23:0] w_limit;

   assign w_rep_cmd = (i_cmd == EDIT_INC) || (i_cmd == EDIT_DEC);
   assign w_limit   = r_first ? DELAY : PERIOD;
   assign o_repeat  = r_active && (i_cmd == r_cmd) && (r_cnt == w_limit);

   // Count from the original acceptance; restart on release or change.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_active <= 1'b0;
         r_first  <= 1'b1;
         r_cnt    <= 24'd0;
         r_cmd    <= EDIT_NONE;
      end else if (i_accept && (!r_active || i_cmd != r_cmd)) begin
         r_active <= w_rep_cmd;
         r_cmd    <= i_cmd;
         r_first  <= 1'b1;
         r_cnt    <= 24'd1;
      end else if (r_active) begin
         if (i_cmd != r_cmd) begin
            r_active <= 1'b0;
         end else if (o_repeat) begin
            r_first <= 1'b0;
            r_cnt   <= 24'd1;
         end else begin
            r_cnt <= r_cnt + 24'd1;
         end
      end
   end

endmodule
`endif

// File: rtl/pattern_cell_editor.sv
// Applies edge-detected edit commands to the cell under the cursor.
// Define EDIT_REPEAT_EN to auto-repeat held increment/decrement.
module pattern_cell_editor
   import tracker_pkg::*;
#(
   parameter int         GRID_W     = GRID_W_DEF,
   parameter int         GRID_H     = GRID_H_DEF,
   parameter logic [7:0] MAX_VAL    = 8'd96,
   parameter int         MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [1:0]  i_user_edit,
   input  logic [6:0]  i_cursor_x,
   input  logic [6:0]  i_cursor_y,
   output logic [11:0] o_mem_addr,
   input  logic [7:0]  i_mem_rd_data,
   output logic [7:0]  o_mem_wr_data,
   output logic        o_mem_we,
   output logic        o_busy,
   output logic        o_edit_done,
   output logic [7:0]  o_cell_value
);

   localparam logic [6:0] W7     = 7'(GRID_W);
   localparam logic [6:0] H7     = 7'(GRID_H);
   localparam logic [1:0] LAT_M1 = 2'(MEM_RD_LAT - 1);

   ed_state_t   r_state;
   edit_t       r_edit_prev;
   edit_t       r_cmd;
   logic [1:0]  r_cnt;
   logic [11:0] r_addr;
   logic [7:0]  r_wr_data;
   logic        r_we;
   logic        r_busy;
   logic        r_done;
   logic [7:0]  r_cell_value;

   edit_t       w_cmd;
   logic [11:0] w_y12;
   logic [11:0] w_addr;
   logic        w_in_range;
   logic        w_edge;
   logic        w_rep_go;
   logic        w_accept;
   logic [7:0]  w_next;

   assign w_cmd      = edit_t'(i_user_edit);
   assign w_y12      = {5'd0, i_cursor_y};
   assign w_addr     = (w_y12 << 6) + (w_y12 << 4) + {5'd0, i_cursor_x};
   assign w_in_range = (i_cursor_x < W7) && (i_cursor_y < H7);
   assign w_edge     = (w_cmd != EDIT_NONE) && (r_edit_prev == EDIT_NONE);
   assign w_accept   = (r_state == ST_IDLE) && (w_edge || w_rep_go) && w_in_range;
   assign w_next     = next_value(r_cmd, i_mem_rd_data, MAX_VAL);

`ifdef EDIT_REPEAT_EN
   logic w_rep_stb;
   logic r_rep_pend;

   edit_repeat_timer u_rep (
      .clk      (clk),
      .Reset    (Reset),
      .i_cmd    (w_cmd),
      .i_accept (w_accept),
      .o_repeat (w_rep_stb)
   );

   assign w_rep_go = (w_rep_stb || r_rep_pend) && (w_cmd == r_cmd);

   // Hold a repeat that falls due while busy until the FSM is idle.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_rep_pend <= 1'b0;
      end else if (w_accept || w_cmd != r_cmd) begin
         r_rep_pend <= 1'b0;
      end else if (w_rep_stb) begin
         r_rep_pend <= 1'b1;
      end
   end
`else
   assign w_rep_go = 1'b0;
`endif

   // Editor FSM: accept, read wait, modify, single-cycle write.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state      <= ST_IDLE;
         r_edit_prev  <= EDIT_NONE;
         r_cmd        <= EDIT_NONE;
         r_cnt        <= 2'd0;
         r_addr       <= 12'd0;
         r_wr_data    <= CELL_EMPTY;
         r_we         <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cell_value <= CELL_EMPTY;
      end else begin
         r_edit_prev <= w_cmd;
         r_we        <= 1'b0;
         r_done      <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_cmd  <= w_cmd;
                  r_addr <= w_addr;
                  r_busy <= 1'b1;
                  r_cnt  <= 2'd0;
                  if (w_cmd == EDIT_DEL) begin
                     r_wr_data    <= CELL_EMPTY;
                     r_cell_value <= CELL_EMPTY;
                     r_we         <= 1'b1;
                     r_done       <= 1'b1;
                     r_state      <= ST_WRITE;
                  end else begin
                     r_state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (r_cnt == LAT_M1) begin
                  r_state <= ST_MODIFY;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            ST_MODIFY: begin
               r_wr_data    <= w_next;
               r_cell_value <= w_next;
               r_we         <= 1'b1;
               r_done       <= 1'b1;
               r_state      <= ST_WRITE;
            end
            ST_WRITE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_mem_addr    = r_addr;
   assign o_mem_wr_data = r_wr_data;
   assign o_mem_we      = r_we;
   assign o_busy        = r_busy;
   assign o_edit_done   = r_done;
   assign o_cell_value  = r_cell_value;

endmodule

// File: tb/tb_pattern_cell_editor.sv
// Scoreboard bench for pattern_cell_editor with a latency-1 RAM model.
// Expected writes are queued at stimulus time and popped on mem_we.
module tb_pattern_cell_editor;

   logic        clk;
   logic        Reset;
   logic [1:0]  i_user_edit;
   logic [6:0]  i_cursor_x;
   logic [6:0]  i_cursor_y;
   logic [11:0] o_mem_addr;
   logic [7:0]  i_mem_rd_data;
   logic [7:0]  o_mem_wr_data;
   logic        o_mem_we;
   logic        o_busy;
   logic        o_edit_done;
   logic [7:0]  o_cell_value;

   typedef struct {
      logic [11:0] a;
      logic [7:0]  d;
      int          c;
   } exp_t;

   exp_t       q[$];
   logic [7:0] mem [0:4095];
   int         cyc;
   int         n_chk;
   int         n_fail;
   int         n_we;

   pattern_cell_editor dut (
      .clk           (clk),
      .Reset         (Reset),
      .i_user_edit   (i_user_edit),
      .i_cursor_x    (i_cursor_x),
      .i_cursor_y    (i_cursor_y),
      .o_mem_addr    (o_mem_addr),
      .i_mem_rd_data (i_mem_rd_data),
      .o_mem_wr_data (o_mem_wr_data),
      .o_mem_we      (o_mem_we),
      .o_busy        (o_busy),
      .o_edit_done   (o_edit_done),
      .o_cell_value  (o_cell_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) i_mem_rd_data <= mem[o_mem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Independent reference for the cell value rules (MAX = 96).
   function automatic logic [7:0] model(input logic [1:0] cmd, input logic [7:0] v);
      case (cmd)
         2'b01: begin
            if (v > 8'd95) return 8'd96;
            return v + 8'd1;
         end
         2'b10: begin
            if (v > 8'd96) return 8'd96;
            if (v == 8'd0 || v == 8'd1) return v;
            return v - 8'd1;
         end
         default: return 8'd0;
      endcase
   endfunction

   // Write monitor: sample away from the active edge.
   always @(negedge clk) begin
      if (o_edit_done !== o_mem_we) chk("done_vs_we", {31'd0, o_edit_done}, {31'd0, o_mem_we});
      if (o_mem_we === 1'b1) begin
         n_we++;
         mem[o_mem_addr] = o_mem_wr_data;
         if (q.size() == 0) begin
            chk("spurious_we", {31'd0, o_mem_we}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("waddr", {20'd0, o_mem_addr}, {20'd0, e.a});
            chk("wdata", {24'd0, o_mem_wr_data}, {24'd0, e.d});
            chk("wcycle", cyc, e.c);
            chk("cellval", {24'd0, o_cell_value}, {24'd0, e.d});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 20; k++) begin
         if (q.size() == 0 && !o_busy) break;
         tick();
      end
      chk({tag, "_drain"}, q.size(), 0);
      chk({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
   endtask

   // Issue one command held for 'hold' cycles, then release.
   task automatic do_cmd(input string tag, input int x, input int y,
                         input logic [1:0] cmd, input logic [7:0] init, input int hold);
      exp_t e;
      bit   inr;
      int   a;
      inr = (x < 80) && (y < 30);
      a   = y * 80 + x;
      if (inr) mem[a] = init;
      i_cursor_x  = 7'(x);
      i_cursor_y  = 7'(y);
      i_user_edit = cmd;
      if (inr) begin
         e.a = 12'(a);
         e.d = model(cmd, init);
         e.c = cyc + ((cmd == 2'b11) ? 1 : 3);
         q.push_back(e);
      end
      for (int k = 0; k < hold; k++) begin
         tick();
         if (k == 0 && inr) begin
            chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
            chk({tag, "_addr"}, {20'd0, o_mem_addr}, a);
         end
         if (k == 0 && !inr) chk({tag, "_nobusy"}, {31'd0, o_busy}, 32'd0);
      end
      i_user_edit = 2'b00;
      tick();
      drain(tag);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"}, {20'd0, o_mem_addr}, 32'd0);
      chk({tag, "_wdata"}, {24'd0, o_mem_wr_data}, 32'd0);
      chk({tag, "_we"}, {31'd0, o_mem_we}, 32'd0);
      chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, o_edit_done}, 32'd0);
      chk({tag, "_cell"}, {24'd0, o_cell_value}, 32'd0);
   endtask

   initial begin
      int w0;
      cyc         = 0;
      n_chk       = 0;
      n_fail      = 0;
      n_we        = 0;
      Reset       = 1'b1;
      i_user_edit = 2'b00;
      i_cursor_x  = 7'd0;
      i_cursor_y  = 7'd0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      repeat (3) tick();
      chk_reset_vals("rst");
      Reset = 1'b0;
      tick();

      do_cmd("inc5", 3, 2, 2'b01, 8'h05, 1);
      do_cmd("incmax", 79, 29, 2'b01, 8'h60, 1);
      do_cmd("dec1", 10, 5, 2'b10, 8'h01, 1);
      do_cmd("dec0", 11, 5, 2'b10, 8'h00, 1);
      do_cmd("dec20", 12, 6, 2'b10, 8'h20, 1);
      do_cmd("inchi", 13, 7, 2'b01, 8'hC8, 1);
      do_cmd("dechi", 14, 7, 2'b10, 8'hFF, 1);
      do_cmd("inc0", 15, 8, 2'b01, 8'h00, 1);
      do_cmd("del", 0, 0, 2'b11, 8'h33, 1);

      w0 = n_we;
      do_cmd("hold", 20, 9, 2'b01, 8'h07, 20);
      chk("hold_writes", n_we - w0, 1);

      // Second command pulsed while busy must be ignored.
      w0 = n_we;
      mem[5 * 80 + 30] = 8'h09;
      i_cursor_x  = 7'd30;
      i_cursor_y  = 7'd5;
      i_user_edit = 2'b01;
      q.push_back('{a: 12'd430, d: 8'h0A, c: cyc + 3});
      tick();
      i_user_edit = 2'b00;
      tick();
      chk("busy_mid", {31'd0, o_busy}, 32'd1);
      i_user_edit = 2'b10;
      tick();
      i_user_edit = 2'b00;
      tick();
      drain("ignore");
      repeat (4) tick();
      chk("ignore_writes", n_we - w0, 1);

      w0 = n_we;
      do_cmd("oor", 80, 0, 2'b01, 8'h00, 1);
      repeat (4) tick();
      chk("oor_writes", n_we - w0, 0);

      // Reset while in READ aborts the operation.
      w0 = n_we;
      mem[2 * 80 + 3] = 8'h10;
      i_cursor_x  = 7'd3;
      i_cursor_y  = 7'd2;
      i_user_edit = 2'b01;
      tick();
      chk("rd_busy", {31'd0, o_busy}, 32'd1);
      Reset       = 1'b1;
      i_user_edit = 2'b00;
      tick();
      chk_reset_vals("abort");
      Reset = 1'b0;
      repeat (4) tick();
      chk("abort_writes", n_we - w0, 0);
      do_cmd("post", 3, 2, 2'b10, 8'h10, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1);
   end

endmodule
